// File: rtl/issue_pkg.sv
// Shared definitions for the issue scheduler: unit codes, default latencies
// and the result-bus reservation entry layout.
package issue_pkg;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_SHF = 2'd1;
    localparam logic [1:0] UNIT_MEM = 2'd2;
    localparam logic [1:0] UNIT_NOP = 2'd3;

    localparam int DEF_ALU_LAT = 1;
    localparam int DEF_SHF_LAT = 2;
    localparam int DEF_MEM_LAT = 3;
    localparam int DEF_MAX_LAT = 4;

    // One reservation of the register-file write port.
    typedef struct packed {
        logic       valid;
        logic [1:0] unit;
        logic [4:0] dest;
        logic       wr;
    } wb_entry_t;

    localparam wb_entry_t WB_ENTRY_NONE = '0;

endpackage

// File: rtl/wb_slot_table.sv
// Shifting result-bus reservation table. Slot k holds the instruction that
// writes back k cycles from now; slot 0 is the current writeback cycle.
// A new reservation is written at an arbitrary index on the same edge the
// table shifts, so the caller must check that the slot shifting into that
// index is free (query port).
module wb_slot_table
    import issue_pkg::*;
#(
    parameter int MAX_LAT = DEF_MAX_LAT,
    parameter int IDX_W   = $clog2(MAX_LAT + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  wb_entry_t        wr_entry,
    input  logic [IDX_W-1:0] query_idx,
    output logic             query_free,
    output wb_entry_t        head
);

    wb_entry_t slot_reg  [MAX_LAT+1];
    wb_entry_t slot_next [MAX_LAT+1];

    genvar gi;
    generate
        for (gi = 0; gi <= MAX_LAT; gi++) begin : g_slot
            if (gi == MAX_LAT) begin : g_top
                // Top slot has nothing above it; only a new reservation can fill it.
                assign slot_next[gi] = (wr_en && wr_idx == IDX_W'(gi)) ? wr_entry : WB_ENTRY_NONE;
            end else begin : g_mid
                // Shift down one slot, unless a new reservation lands here.
                assign slot_next[gi] = (wr_en && wr_idx == IDX_W'(gi)) ? wr_entry : slot_reg[gi+1];
            end
        end
    endgenerate

    // Table register: cleared on reset so no stale writeback survives it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                slot_reg[k] <= WB_ENTRY_NONE;
            end
        end else begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                slot_reg[k] <= slot_next[k];
            end
        end
    end

    // Slot-free query; indices above the table are always free.
    always_comb begin
        query_free = 1'b1;
        for (int k = 0; k <= MAX_LAT; k++) begin
            if (query_idx == IDX_W'(k)) begin
                query_free = !slot_reg[k].valid;
            end
        end
    end

    assign head = slot_reg[0];

endmodule

// File: rtl/issue_scheduler.sv
// Scoreboard issue controller: tracks pending destinations and busy units,
// reserves the single register-file write port, and decides issue/stall
// for the decoded instruction every cycle.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int ALU_LAT = DEF_ALU_LAT,
    parameter int SHF_LAT = DEF_SHF_LAT,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int MAX_LAT = DEF_MAX_LAT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_is_valid,
    input  logic [1:0]  id_is_unit,
    input  logic [4:0]  id_is_addra,
    input  logic [4:0]  id_is_addrb,
    input  logic        id_is_useb,
    input  logic [4:0]  id_is_regdest,
    input  logic        id_is_writereg,
    output logic        is_stall,
    output logic        is_ex_issue,
    output logic [1:0]  is_ex_func_unit,
    output logic [4:0]  is_ex_regdest,
    output logic        is_wb_valid,
    output logic [4:0]  is_wb_addr,
    output logic [1:0]  is_wb_unit,
    output logic [31:0] is_pending
);

    localparam int IDX_W = $clog2(MAX_LAT + 2);

    logic [31:0]      pending_reg, pending_next, pend_eff, head_dest_mask;
    logic [3:0]       busy_reg, busy_next, busy_eff, head_unit_mask;
    logic [IDX_W-1:0] issue_lat, query_idx;
    logic             slot_free, is_nop, src_a_ok, src_b_ok, waw_ok, issue, reserve;
    wb_entry_t        head, new_entry;

    // Latency of the decoded unit selects where its reservation lands.
    always_comb begin
        issue_lat = '0;
        case (id_is_unit)
            UNIT_ALU: issue_lat = IDX_W'(ALU_LAT);
            UNIT_SHF: issue_lat = IDX_W'(SHF_LAT);
            UNIT_MEM: issue_lat = IDX_W'(MEM_LAT);
            default:  issue_lat = '0;
        endcase
    end

    // The slot above L shifts into L on the issuing edge, so it must be empty.
    assign query_idx = issue_lat + IDX_W'(1);
    assign new_entry = '{valid: 1'b1, unit: id_is_unit, dest: id_is_regdest, wr: id_is_writereg};

    wb_slot_table #(
        .MAX_LAT (MAX_LAT),
        .IDX_W   (IDX_W)
    ) u_table (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (reserve),
        .wr_idx     (issue_lat),
        .wr_entry   (new_entry),
        .query_idx  (query_idx),
        .query_free (slot_free),
        .head       (head)
    );

    // Write-through bypass: the writeback happening now frees its dest and unit.
    always_comb begin
        head_dest_mask = head.valid ? (32'd1 << head.dest) : 32'd0;
        head_unit_mask = head.valid ? (4'd1 << head.unit) : 4'd0;
        pend_eff       = pending_reg & ~head_dest_mask;
        busy_eff       = busy_reg & ~head_unit_mask;
    end

    // Issue decision: operands ready, no WAW, unit idle, write port slot free.
    always_comb begin
        is_nop   = (id_is_unit == UNIT_NOP);
        src_a_ok = (id_is_addra == 5'd0) || !pend_eff[id_is_addra];
        src_b_ok = !id_is_useb || (id_is_addrb == 5'd0) || !pend_eff[id_is_addrb];
        waw_ok   = !id_is_writereg || (id_is_regdest == 5'd0) || !pend_eff[id_is_regdest];
        if (is_nop) begin
            issue = id_is_valid;
        end else begin
            issue = id_is_valid && !busy_eff[id_is_unit] && src_a_ok && src_b_ok
                    && waw_ok && slot_free;
        end
        reserve  = issue && !is_nop;
        is_stall = id_is_valid && !issue;
    end

    // Scoreboard next state: writeback clears first, a same-edge issue sets over it.
    always_comb begin
        pending_next = pending_reg & ~head_dest_mask;
        busy_next    = busy_reg & ~head_unit_mask;
        if (reserve) begin
            busy_next[id_is_unit] = 1'b1;
            if (id_is_writereg && id_is_regdest != 5'd0) begin
                pending_next[id_is_regdest] = 1'b1;
            end
        end
        pending_next[0] = 1'b0;
        busy_next[3]    = 1'b0;
    end

    // Scoreboard registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
            busy_reg    <= '0;
        end else begin
            pending_reg <= pending_next;
            busy_reg    <= busy_next;
        end
    end

    // Execute-stage handoff: one-cycle issue pulse, unit/dest hold between issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_ex_issue     <= 1'b0;
            is_ex_func_unit <= 2'd0;
            is_ex_regdest   <= 5'd0;
        end else begin
            is_ex_issue <= issue;
            if (issue) begin
                is_ex_func_unit <= id_is_unit;
                is_ex_regdest   <= id_is_regdest;
            end
        end
    end

    assign is_wb_valid = head.valid && head.wr && (head.dest != 5'd0);
    assign is_wb_addr  = head.dest;
    assign is_wb_unit  = head.unit;
    assign is_pending  = pending_reg;

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Scoreboard-style issue controller sitting between decode and the functional units.
- Tracks pending destination registers and per-unit busy state, and holds a result-bus reservation table so the single register-file write port is never oversubscribed.
- Decides each cycle whether the decoded instruction issues or stalls.
- Drives the writeback address/valid seen by the register file.

Parameters:
- ALU_LAT, 1, cycles from issue to writeback for the ALU unit (1..MAX_LAT).
- SHF_LAT, 2, same for the shifter unit (1..MAX_LAT).
- MEM_LAT, 3, same for the memory unit (1..MAX_LAT).
- MAX_LAT, 4, reservation table depth minus one.

Ports:
- clock  in  1  Single clock, rising edge.
- reset  in  1  Asynchronous, active-high.
- id_is_valid  in  1  Decoded instruction present.
- id_is_unit  in  2  Unit code: 0 = ALU, 1 = SHF, 2 = MEM, 3 = NOP.
- id_is_addra  in  5  Source A register.
- id_is_addrb  in  5  Source B register.
- id_is_useb  in  1  Source B is read.
- id_is_regdest  in  5  Destination register.
- id_is_writereg  in  1  Instruction writes regdest.
- is_stall  out  1  Combinational; decode must hold its inputs.
- is_ex_issue  out  1  Registered one-cycle pulse per issued instruction.
- is_ex_func_unit  out  2  Registered unit code of the issued instruction.
- is_ex_regdest  out  5  Registered destination of the issued instruction.
- is_wb_valid  out  1  A register write happens this cycle.
- is_wb_addr  out  5  Register written this cycle.
- is_wb_unit  out  2  Unit whose result is on the write bus.
- is_pending  out  32  Pending bitmap; bit 0 is always 0.

Behaviour:
- Reset (asynchronous, active-high): pending = 0, busy = 0, all table entries invalid, is_ex_issue = 0, is_ex_func_unit = 0, is_ex_regdest = 0, is_wb_valid = 0, is_wb_addr = 0, is_wb_unit = 0.
  - Reset asserted mid-operation discards all in-flight entries; no writeback occurs after reset.
- L(unit): ALU_LAT, SHF_LAT or MEM_LAT.
- Reservation table: entries at indices 0..MAX_LAT, each holding {valid, unit, dest, wr}.
  - Every edge, entry[k] <= entry[k+1]; entry[MAX_LAT] <= invalid.
  - Entry[0] is the writeback cycle:
    - is_wb_valid = entry[0].valid & wr & (dest != 0).
    - is_wb_addr = entry[0].dest; is_wb_unit = entry[0].unit.
- Effective state in the current cycle:
  - pend_eff: pending with the entry[0] dest bit masked (write-through bypass).
  - busy_eff: busy with the entry[0] unit masked.
- Issue condition (combinational) for a non-NOP instruction:
  - id_is_valid.
  - !busy_eff[unit].
  - addra == 0 or !pend_eff[addra].
  - !useb, or addrb == 0, or !pend_eff[addrb].
  - !writereg, or regdest == 0, or !pend_eff[regdest] (WAW check).
  - entry[L+1] invalid; index MAX_LAT+1 counts as invalid.
- NOP (unit 3) issues whenever valid; it reserves nothing and sets no pending bit.
- is_stall = id_is_valid & !issue.
- On the issuing edge:
  - is_ex_issue <= 1; is_ex_func_unit/is_ex_regdest latch the inputs.
  - busy[unit] <= 1.
  - entry[L] <= {1, unit, regdest, writereg}.
  - pending[regdest] <= 1 if writereg and regdest != 0.
- Non-issue edge: is_ex_issue <= 0; the other is_ex_* outputs hold.
- Writeback edge (entry[0] valid): busy[entry[0].unit] <= 0; pending[entry[0].dest] <= 0.
- Same-edge conflict: issue set beats writeback clear, for both the pending bit and busy.
- Timing: is_wb_valid is high exactly L cycles after the cycle in which is_ex_issue is high.
- Units are non-pipelined: one instruction per unit in flight.
- Register 0 is never marked pending and never written back.

Decomposition:
- Package issue_pkg holds:
  - Unit codes UNIT_ALU/SHF/MEM/NOP.
  - Default latencies.
  - Reservation entry struct {valid, unit[1:0], dest[4:0], wr}.
- One sub-module, wb_slot_table: the shifting reservation table with a write-at-index port, a slot-free query and the entry[0] output.
- Pending/busy logic and the issue decision stay at top level.

Test Plan:
1. Reset asserted mid-flight (MEM issued 1 cycle earlier), then released -> is_pending = 0, is_wb_valid never rises, is_stall = 0 with valid = 0.
2. ALU r3 <- r1,r2 presented cycle 0:
   - is_ex_issue = 1 and unit = 0 in cycle 1; is_pending[3] = 1 in cycle 1.
   - is_wb_valid = 1 with addr = 3 in cycle 2; is_pending[3] = 0 in cycle 3.
3. MEM load r5 at cycle 0, ALU reading r5 at cycle 1 -> is_stall = 1 in cycles 1-3; ALU issues in cycle 4 (bypass) with is_ex_issue in cycle 5.
4. MEM r6 at cycle 0, SHF r7 at cycle 1 -> SHF stalls in cycle 1 (both would write back in cycle 4). SHF issues from cycle 2; writebacks: r6 in cycle 4, r7 in cycle 5.
5. Two independent ALU instructions back to back (cycles 0 and 1) -> second stalls in cycle 1 and issues in cycle 2 (first's writeback cycle); is_ex_issue in cycles 1 and 3.
6. ALU with regdest = 0 and writereg = 1 -> is_pending stays 0, is_wb_valid stays 0, ALU busy is released in cycle 2.
